// File: rtl/calc_pkg.sv
// Shared calculator types plus the arbiter's state encoding and round-robin pick helper.
// No timing of its own; everything here is types and a pure combinational function.
// Backpressure: not applicable.
package calc_pkg;

   localparam int unsigned NumW   = 16;
   // Upper bound on requesters that rr_pick can search over.
   localparam int unsigned MaxReq = 32;

   typedef logic [NumW-1:0] num_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_COLLECT = 2'd2,
      S_RETURN  = 2'd3
   } arb_state_t;

   // Mask-and-priority round robin: lowest set request at or above ptr wins;
   // if none is there, fall back to the lowest set request overall.
   // Returns 0 when nothing is requested (caller qualifies with |req).
   function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                           input int unsigned       n,
                                           input int unsigned       ptr);
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         if (!found && i >= ptr && i < n && req[i]) begin
            idx   = i;
            found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < MaxReq; i++) begin
         if (!found && i < n && req[i]) begin
            idx   = i;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ALU-side handshake bundle: operands/op with in_valid/in_ready, result with out_valid/out_ready.
// Pure wiring, no latency.
// Backpressure: in_ready stalls issue, out_valid gates collection.
interface alu_arbiter_if;
   import calc_pkg::*;

   num_t left;
   num_t right;
   op_t  op;
   logic in_valid;
   logic in_ready;
   num_t result;
   logic out_valid;
   logic out_ready;

   // master: the arbiter driving the ALU
   modport master (
      output left, right, op, in_valid, out_ready,
      input  in_ready, result, out_valid
   );

   // slave: the ALU itself
   modport slave (
      input  left, right, op, in_valid, out_ready,
      output in_ready, result, out_valid
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: request vector + pointer -> one-hot grant and index.
// Zero latency.
// Backpressure: none; grant is all-zero when no request is present.
module rr_arbiter
   import calc_pkg::*;
#(
   parameter int unsigned NumReq = 2
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] ptr_i,
   output logic [NumReq-1:0]         gnt_o,
   output logic [$clog2(NumReq)-1:0] idx_o,
   output logic                      vld_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   logic [MaxReq-1:0] req_ext;
   int unsigned       pick;

   assign req_ext = MaxReq'(req_i);
   assign vld_o   = |req_i;

   always_comb begin
      pick = rr_pick(req_ext, NumReq, 32'(ptr_i));
   end

   assign idx_o = IdxW'(pick);

   always_comb begin
      gnt_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         gnt_o[i] = vld_o && (pick == i);
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one calc ALU between NumReq requesters, round-robin, one transaction in flight.
// Latency: accept N, alu_in_valid N+1, alu_out_ready N+2, req_out_valid N+3 (4-cycle throughput).
// Backpressure: req_in_ready only in idle; ALU/requester stalls hold state. ALU_ARB_TIMEOUT_EN adds a watchdog.
//
// Ports: clk_i/rst_ni (async active-low); req_* per-requester operand/op/valid in, one-hot
// ready/valid out with a shared result and error flag; alu (master modport) to the ALU.
module alu_arbiter
   import calc_pkg::*;
#(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  num_t              req_left_i  [NumReq],
   input  num_t              req_right_i [NumReq],
   input  op_t               req_op_i    [NumReq],
   input  logic [NumReq-1:0] req_in_valid_i,
   output logic [NumReq-1:0] req_in_ready_o,
   output num_t              req_result_o,
   output logic              req_err_o,
   output logic [NumReq-1:0] req_out_valid_o,
   input  logic [NumReq-1:0] req_out_ready_i,
   alu_arbiter_if.master     alu
);

   localparam int unsigned IdxW = $clog2(NumReq);

   arb_state_t state_q, state_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0] grant_q, grant_d;
   num_t left_q, left_d;
   num_t right_q, right_d;
   op_t  op_q, op_d;
   num_t result_q, result_d;

   logic [NumReq-1:0] pick_gnt;
   logic [IdxW-1:0]   pick_idx;
   logic              pick_vld;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            expired;
   assign expired = (cnt_q == CntW'(TimeoutCycles - 1));
`else
   localparam int unsigned unused_timeout_cycles = TimeoutCycles;
`endif

   rr_arbiter #(.NumReq(NumReq)) u_rr (
      .req_i (req_in_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_d        = grant_q;
      left_d         = left_q;
      right_d        = right_q;
      op_d           = op_q;
      result_d       = result_q;
      req_in_ready_o = '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_d          = cnt_q;
      err_d          = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            // The only combinational output: ready follows the live pick.
            req_in_ready_o = pick_gnt;
            if (pick_vld) begin
               left_d  = req_left_i[pick_idx];
               right_d = req_right_i[pick_idx];
               op_d    = req_op_i[pick_idx];
               grant_d = pick_idx;
               state_d = S_ISSUE;
`ifdef ALU_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_ISSUE: begin
            // out_valid is deliberately not looked at here; collection starts next state.
            if (alu.in_ready) begin
               state_d = S_COLLECT;
            end
`ifdef ALU_ARB_TIMEOUT_EN
            else if (expired) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_RETURN;
            end
            cnt_d = cnt_q + CntW'(1);
`endif
         end
         S_COLLECT: begin
            if (alu.out_valid) begin
               result_d = alu.result;
               state_d  = S_RETURN;
`ifdef ALU_ARB_TIMEOUT_EN
               err_d    = 1'b0;
`endif
            end
`ifdef ALU_ARB_TIMEOUT_EN
            else if (expired) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_RETURN;
            end
            cnt_d = cnt_q + CntW'(1);
`endif
         end
         S_RETURN: begin
            if (req_out_ready_i[grant_q]) begin
               rr_ptr_d = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);
               state_d  = S_IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
               err_d    = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         left_q   <= '0;
         right_q  <= '0;
         op_q     <= OP_ADD;
         result_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         left_q   <= left_d;
         right_q  <= right_d;
         op_q     <= op_d;
         result_q <= result_d;
`ifdef ALU_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   // Moore outputs, decoded from registered state only.
   assign alu.left      = left_q;
   assign alu.right     = right_q;
   assign alu.op        = op_q;
   assign alu.in_valid  = (state_q == S_ISSUE);
   assign alu.out_ready = (state_q == S_COLLECT);
   assign req_result_o  = result_q;

`ifdef ALU_ARB_TIMEOUT_EN
   assign req_err_o = err_q;
`else
   assign req_err_o = 1'b0;
`endif

   always_comb begin
      req_out_valid_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         req_out_valid_o[i] = (state_q == S_RETURN) && (grant_q == IdxW'(i));
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, both backpressure sides,
// asynchronous reset mid-operation, and (with ALU_ARB_TIMEOUT_EN) the watchdog path.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_alu_arbiter;
   import calc_pkg::*;

   localparam int unsigned NR = 2;
`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   num_t        req_left  [NR];
   num_t        req_right [NR];
   op_t         req_op    [NR];
   logic [1:0]  in_vld, in_rdy, out_vld, out_rdy;
   num_t        res;
   logic        err;
   logic        alu_in_rdy, alu_out_vld;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_arbiter_if alu_bus ();

   assign alu_bus.in_ready  = alu_in_rdy;
   assign alu_bus.out_valid = alu_out_vld;

   // Behavioural ALU: result is a function of whatever operands the arbiter presents.
   always_comb begin
      alu_bus.result = '0;
      case (alu_bus.op)
         OP_ADD: alu_bus.result = alu_bus.left + alu_bus.right;
         OP_SUB: alu_bus.result = alu_bus.left - alu_bus.right;
         OP_MUL: alu_bus.result = alu_bus.left * alu_bus.right;
         OP_DIV: alu_bus.result = (alu_bus.right == '0) ? '0 : alu_bus.left / alu_bus.right;
         default: alu_bus.result = '0;
      endcase
   end

   alu_arbiter #(.NumReq(NR), .TimeoutCycles(TO)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_left_i      (req_left),
      .req_right_i     (req_right),
      .req_op_i        (req_op),
      .req_in_valid_i  (in_vld),
      .req_in_ready_o  (in_rdy),
      .req_result_o    (res),
      .req_err_o       (err),
      .req_out_valid_o (out_vld),
      .req_out_ready_i (out_rdy),
      .alu             (alu_bus.master)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      in_vld = 2'b00;
      #1;
      n_cmp++; if (in_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_in_rdy got=%b want=00", in_rdy); end
      n_cmp++; if (alu_bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_in_valid got=%b want=0", alu_bus.in_valid); end
      n_cmp++; if (alu_bus.out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_out_ready got=%b want=0", alu_bus.out_ready); end
      n_cmp++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL reset_out_vld got=%b want=00", out_vld); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err); end
      n_cmp++; if (res !== 16'd0) begin n_fail++; $display("FAIL reset_result got=%0d want=0", res); end
      n_cmp++; if (alu_bus.left !== 16'd0 || alu_bus.right !== 16'd0) begin n_fail++; $display("FAIL reset_operands got=%0d,%0d want=0,0", alu_bus.left, alu_bus.right); end
      n_cmp++; if (alu_bus.op !== OP_ADD) begin n_fail++; $display("FAIL reset_op got=%0d want=%0d", alu_bus.op, OP_ADD); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      req_left[0] = 16'd3; req_right[0] = 16'd4; req_op[0] = OP_ADD; in_vld = 2'b01;
      @(negedge clk);
      n_cmp++; if (in_rdy !== 2'b01) begin n_fail++; $display("FAIL single_accept got=%b want=01", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      @(negedge clk);   // accept+1
      n_cmp++; if (alu_bus.in_valid !== 1'b1) begin n_fail++; $display("FAIL single_in_valid got=%b want=1", alu_bus.in_valid); end
      n_cmp++; if (alu_bus.left !== 16'd3 || alu_bus.right !== 16'd4 || alu_bus.op !== OP_ADD) begin n_fail++; $display("FAIL single_operands got=%0d,%0d,%0d want=3,4,0", alu_bus.left, alu_bus.right, alu_bus.op); end
      n_cmp++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL single_early_out got=%b want=00", out_vld); end
      @(negedge clk);   // accept+2
      n_cmp++; if (alu_bus.out_ready !== 1'b1 || alu_bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL single_collect got=out_rdy %b in_vld %b want=1 0", alu_bus.out_ready, alu_bus.in_valid); end
      @(negedge clk);   // accept+3
      n_cmp++; if (out_vld !== 2'b01) begin n_fail++; $display("FAIL single_out_vld got=%b want=01", out_vld); end
      n_cmp++; if (res !== 16'd7) begin n_fail++; $display("FAIL single_result got=%0d want=7", res); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b want=0", err); end
      @(negedge clk);
      n_cmp++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL single_out_drop got=%b want=00", out_vld); end
   endtask

   task automatic test_contention();
      int grants;
      int last_c;
      int last_g;
      logic [1:0] exp_gnt;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      req_left[0] = 16'd10; req_right[0] = 16'd3; req_op[0] = OP_SUB;
      req_left[1] = 16'd6;  req_right[1] = 16'd7; req_op[1] = OP_MUL;
      in_vld = 2'b11;
      grants = 0; last_c = 0; last_g = 0;
      for (int c = 0; c < 40 && grants < 4; c++) begin
         @(negedge clk);
         n_cmp++; if ($countones(in_rdy) > 1) begin n_fail++; $display("FAIL contend_onehot got=%b want=at most one bit", in_rdy); end
         if (out_vld !== 2'b00) begin
            n_cmp++; if (out_vld !== ((last_g == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL contend_out_route got=%b want=req%0d", out_vld, last_g); end
            n_cmp++; if (res !== ((last_g == 0) ? 16'd7 : 16'd42)) begin n_fail++; $display("FAIL contend_result got=%0d want=%0d", res, (last_g == 0) ? 7 : 42); end
         end
         if (in_rdy !== 2'b00) begin
            exp_gnt = (grants % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (in_rdy !== exp_gnt) begin n_fail++; $display("FAIL contend_grant%0d got=%b want=%b", grants, in_rdy, exp_gnt); end
            if (grants > 0) begin
               n_cmp++; if (c - last_c != 4) begin n_fail++; $display("FAIL contend_spacing got=%0d want=4", c - last_c); end
            end
            last_c = c;
            last_g = (in_rdy == 2'b10) ? 1 : 0;
            grants++;
         end
      end
      n_cmp++; if (grants != 4) begin n_fail++; $display("FAIL contend_grant_count got=%0d want=4", grants); end
      @(posedge clk); #1 in_vld = 2'b00;
      repeat (6) @(posedge clk);
   endtask

   task automatic test_alu_backpressure();
      logic ok;
      #1;
      alu_in_rdy = 1'b0;
      req_left[1] = 16'd100; req_right[1] = 16'd1; req_op[1] = OP_SUB; in_vld = 2'b10;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (in_rdy === 2'b10) ok = 1'b1;
      end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL alubp_accept got=%b want=10 within 10 cycles", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (alu_bus.in_valid !== 1'b1 || alu_bus.out_ready !== 1'b0) begin n_fail++; $display("FAIL alubp_hold%0d got=in_vld %b out_rdy %b want=1 0", k, alu_bus.in_valid, alu_bus.out_ready); end
         n_cmp++; if (alu_bus.left !== 16'd100 || alu_bus.right !== 16'd1 || alu_bus.op !== OP_SUB) begin n_fail++; $display("FAIL alubp_stable%0d got=%0d,%0d,%0d want=100,1,1", k, alu_bus.left, alu_bus.right, alu_bus.op); end
      end
      alu_in_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (alu_bus.out_ready !== 1'b1) begin n_fail++; $display("FAIL alubp_collect got=%b want=1", alu_bus.out_ready); end
      @(negedge clk);
      n_cmp++; if (out_vld !== 2'b10 || res !== 16'd99) begin n_fail++; $display("FAIL alubp_result got=%b/%0d want=10/99", out_vld, res); end
   endtask

   task automatic test_out_backpressure();
      logic ok;
      @(posedge clk); #1;
      out_rdy = 2'b10;   // only the non-granted requester is ready; must be ignored
      req_left[0] = 16'd5; req_right[0] = 16'd9; req_op[0] = OP_ADD; in_vld = 2'b01;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (in_rdy === 2'b01) ok = 1'b1;
      end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL outbp_accept got=%b want=01", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (out_vld === 2'b01) ok = 1'b1;
      end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL outbp_return got=%b want=01", out_vld); end
      req_left[1] = 16'd8; req_right[1] = 16'd5; req_op[1] = OP_SUB; in_vld = 2'b10;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (out_vld !== 2'b01 || res !== 16'd14) begin n_fail++; $display("FAIL outbp_hold%0d got=%b/%0d want=01/14", k, out_vld, res); end
         n_cmp++; if (in_rdy !== 2'b00) begin n_fail++; $display("FAIL outbp_no_accept%0d got=%b want=00", k, in_rdy); end
         @(negedge clk);
      end
      out_rdy = 2'b11;
      @(negedge clk);
      n_cmp++; if (out_vld !== 2'b00 || in_rdy !== 2'b10) begin n_fail++; $display("FAIL outbp_release got=out %b in_rdy %b want=00 10", out_vld, in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (out_vld === 2'b10) ok = 1'b1;
      end
      n_cmp++; if (!ok || res !== 16'd3) begin n_fail++; $display("FAIL outbp_second got=%b/%0d want=10/3", out_vld, res); end
   endtask

   task automatic test_reset_mid();
      logic ok;
      @(posedge clk); #1;
      // Complete one req0 op first so the pointer moves away from 0.
      req_left[0] = 16'd1; req_right[0] = 16'd1; req_op[0] = OP_ADD; in_vld = 2'b01;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (in_rdy === 2'b01) ok = 1'b1; end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_first_accept got=%b want=01", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (out_vld === 2'b01) ok = 1'b1; end
      n_cmp++; if (!ok || res !== 16'd2) begin n_fail++; $display("FAIL rstmid_first_result got=%b/%0d want=01/2", out_vld, res); end
      @(posedge clk); #1;
      alu_out_vld = 1'b0;
      req_left[1] = 16'd2; req_right[1] = 16'd2; req_op[1] = OP_MUL; in_vld = 2'b10;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (in_rdy === 2'b10) ok = 1'b1; end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept got=%b want=10", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (alu_bus.out_ready === 1'b1) ok = 1'b1; end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_collect got=%b want=1", alu_bus.out_ready); end
      #2 rst_n = 1'b0;   // between edges: must take effect without a clock
      #1;
      n_cmp++; if (alu_bus.out_ready !== 1'b0 || alu_bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_alu_side got=out_rdy %b in_vld %b want=0 0", alu_bus.out_ready, alu_bus.in_valid); end
      n_cmp++; if (out_vld !== 2'b00 || err !== 1'b0 || res !== 16'd0) begin n_fail++; $display("FAIL rstmid_req_side got=%b/%b/%0d want=00/0/0", out_vld, err, res); end
      n_cmp++; if (alu_bus.left !== 16'd0 || alu_bus.right !== 16'd0 || alu_bus.op !== OP_ADD) begin n_fail++; $display("FAIL rstmid_operands got=%0d,%0d,%0d want=0,0,0", alu_bus.left, alu_bus.right, alu_bus.op); end
      alu_out_vld = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_vld = 2'b11;
      @(negedge clk);
      n_cmp++; if (in_rdy !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_after got=%b want=01", in_rdy); end
      in_vld = 2'b00;   // withdrawn before the edge, so nothing is accepted
      repeat (2) @(posedge clk);
   endtask

`ifdef ALU_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic ok;
      @(posedge clk); #1;
      alu_out_vld = 1'b0;
      out_rdy = 2'b00;
      req_left[0] = 16'd7; req_right[0] = 16'd7; req_op[0] = OP_ADD; in_vld = 2'b01;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (in_rdy === 2'b01) ok = 1'b1; end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_accept got=%b want=01", in_rdy); end
      @(posedge clk); #1 in_vld = 2'b00;
      ok = 1'b0;
      for (int c = 0; c < 30 && !ok; c++) begin @(negedge clk); if (out_vld === 2'b01) ok = 1'b1; end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_return got=%b want=01", out_vld); end
      n_cmp++; if (res !== 16'd0 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_flags got=%0d/%b want=0/1", res, err); end
      out_rdy = 2'b11;
      alu_out_vld = 1'b1;
      @(negedge clk);
      n_cmp++; if (err !== 1'b0 || out_vld !== 2'b00) begin n_fail++; $display("FAIL timeout_clear got=%b/%b want=0/00", err, out_vld); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=simulation still running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         req_left[i] = '0; req_right[i] = '0; req_op[i] = OP_ADD;
      end
      in_vld = 2'b00;
      out_rdy = 2'b11;
      alu_in_rdy = 1'b1;
      alu_out_vld = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_alu_backpressure();
      test_out_backpressure();
      test_reset_mid();
`ifdef ALU_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
